// File: rtl/vertex_stream_arbiter_if.sv
// Requester-side and assembler-side handshake bundle for the vertex arbiter.
interface vertex_stream_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*128-1:0] req_vertex;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   pa_valid;
    logic [31:0]            pa_vertex_x;
    logic [31:0]            pa_vertex_y;
    logic [31:0]            pa_vertex_z;
    logic [31:0]            pa_vertex_w;
    logic                   pa_ready;

    modport master (
        input  req_valid,
        input  req_vertex,
        output req_ready,
        output pa_valid,
        output pa_vertex_x,
        output pa_vertex_y,
        output pa_vertex_z,
        output pa_vertex_w,
        input  pa_ready
    );

    modport slave (
        output req_valid,
        output req_vertex,
        input  req_ready,
        input  pa_valid,
        input  pa_vertex_x,
        input  pa_vertex_y,
        input  pa_vertex_z,
        input  pa_vertex_w,
        output pa_ready
    );
endinterface

// File: rtl/vertex_stream_arbiter.sv
// Triangle-atomic round-robin arbiter feeding one primitive assembly port.
// A granted requester owns the port for exactly three accepted vertices.
module vertex_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    vertex_stream_arbiter_if.master bus,
    output logic [IDW-1:0]       grant_id,
    output logic [1:0]           vtx_idx,
    output logic                 busy,
    output logic [CNT_W-1:0]     tri_count
);
    localparam int NSLOT = 1 << IDW;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   r_rr;
    logic [1:0]       r_vtx;
    logic [CNT_W-1:0] r_tri;

    logic [NSLOT-1:0] w_vld_ext;
    logic [IDW-1:0]   w_pick;
    logic             w_any;
    logic             w_xfer;
    logic             w_last;
    logic [127:0]     w_sel;

    // (a + k) mod NUM_REQ for a < NUM_REQ and k < NUM_REQ
    function automatic logic [IDW-1:0] wrap_add(
        input logic [IDW-1:0] a,
        input int             k
    );
        int s;
        s = int'(a) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    assign w_vld_ext = NSLOT'(bus.req_valid);

    // Descending scan so the entry closest to r_rr wins
    always_comb begin
        w_pick = r_rr;
        w_any  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_vld_ext[wrap_add(r_rr, k)]) begin
                w_pick = wrap_add(r_rr, k);
                w_any  = 1'b1;
            end
        end
    end

    assign busy   = (r_state == S_GRANT);
    assign w_xfer = busy && w_vld_ext[r_grant] && bus.pa_ready;
    assign w_last = (r_vtx == 2'd2);

    assign w_sel           = bus.req_vertex[{r_grant, 7'd0} +: 128];
    assign bus.pa_valid    = busy && w_vld_ext[r_grant];
    assign bus.pa_vertex_x = w_sel[31:0];
    assign bus.pa_vertex_y = w_sel[63:32];
    assign bus.pa_vertex_z = w_sel[95:64];
    assign bus.pa_vertex_w = w_sel[127:96];

    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = busy && bus.pa_ready && (r_grant == IDW'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_GRANT;
            S_GRANT: if (w_xfer && w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_vtx   <= '0;
            r_rr    <= '0;
            r_tri   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_any) begin
                r_grant <= w_pick;
                r_vtx   <= '0;
            end
            if (w_xfer) begin
                if (w_last) begin
                    r_vtx <= '0;
                    r_rr  <= wrap_add(r_grant, 1);
                    r_tri <= r_tri + 1'b1;
                end else begin
                    r_vtx <= r_vtx + 2'd1;
                end
            end
        end
    end

    assign grant_id  = r_grant;
    assign vtx_idx   = r_vtx;
    assign tri_count = r_tri;
endmodule

// File: tb/tb_vertex_stream_arbiter.sv
// Directed bench for vertex_stream_arbiter; a second CNT_W=2 copy
// shares the stimulus to exercise counter wrap.
module tb_vertex_stream_arbiter;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;
    localparam int CNT_W   = 16;

    logic clk = 1'b0;
    logic rst;

    logic [IDW-1:0]   grant_id, grant_id2;
    logic [1:0]       vtx_idx, vtx_idx2;
    logic             busy, busy2;
    logic [CNT_W-1:0] tri_count;
    logic [1:0]       tri_count2;

    int n_cmp = 0;
    int n_err = 0;

    vertex_stream_arbiter_if #(.NUM_REQ(NUM_REQ)) u_if ();
    vertex_stream_arbiter_if #(.NUM_REQ(NUM_REQ)) u_if2 ();

    assign u_if2.req_valid  = u_if.req_valid;
    assign u_if2.req_vertex = u_if.req_vertex;
    assign u_if2.pa_ready   = u_if.pa_ready;

    vertex_stream_arbiter #(
        .NUM_REQ(NUM_REQ), .IDW(IDW), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(u_if.master),
        .grant_id(grant_id), .vtx_idx(vtx_idx),
        .busy(busy), .tri_count(tri_count)
    );

    vertex_stream_arbiter #(
        .NUM_REQ(NUM_REQ), .IDW(IDW), .CNT_W(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .bus(u_if2.master),
        .grant_id(grant_id2), .vtx_idx(vtx_idx2),
        .busy(busy2), .tri_count(tri_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h need %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_vtx(input int i, input logic [31:0] x);
        u_if.req_vertex[128*i +: 128] = {x + 32'h300, x + 32'h200,
                                         x + 32'h100, x};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        u_if.req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] exp_wrap [5];
    int         nx;
    logic [4:0] bp;

    initial begin
        exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1;
        u_if.req_valid = '0;
        u_if.pa_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_vtx(i, 32'(16 * (i + 1)));
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vtx", 32'(vtx_idx), 32'd0);
        chk("rst_tri", 32'(tri_count), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_pav", 32'(u_if.pa_valid), 32'd0);
        chk("rst_rdy", 32'(u_if.req_ready), 32'd0);

        // single requester
        rst = 1'b0;
        u_if.req_valid = 4'b0001;
        #1;
        chk("s_idle_busy", 32'(busy), 32'd0);
        chk("s_idle_rdy", 32'(u_if.req_ready), 32'd0);
        for (int t = 0; t < 2; t++) begin
            for (int v = 0; v < 3; v++) begin
                tick();
                chk("s_busy", 32'(busy), 32'd1);
                chk("s_grant", 32'(grant_id), 32'd0);
                chk("s_vtx", 32'(vtx_idx), 32'(v));
                chk("s_rdy", 32'(u_if.req_ready), 32'b0001);
                chk("s_pav", 32'(u_if.pa_valid), 32'd1);
            end
            tick();
            chk("s_bubble", 32'(busy), 32'd0);
            chk("s_bub_rdy", 32'(u_if.req_ready), 32'd0);
            chk("s_tri", 32'(tri_count), 32'(t + 1));
        end

        // round robin
        do_reset();
        u_if.req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            for (int v = 0; v < 3; v++) begin
                tick();
                chk("rr_grant", 32'(grant_id), 32'(t % 4));
                chk("rr_vtx", 32'(vtx_idx), 32'(v));
                chk("rr_rdy", 32'(u_if.req_ready), 32'(1 << (t % 4)));
                chk("rr_x", u_if.pa_vertex_x, 32'(16 * ((t % 4) + 1)));
            end
            tick();
            chk("rr_idle", 32'(busy), 32'd0);
        end
        chk("rr_tri5", 32'(tri_count), 32'd5);

        // atomicity under contention
        do_reset();
        u_if.req_valid = 4'b0010;
        tick();
        chk("at_grant", 32'(grant_id), 32'd1);
        u_if.req_valid = 4'b0110;
        tick();
        chk("at_vtx1", 32'(vtx_idx), 32'd1);
        u_if.req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("at_hold_g", 32'(grant_id), 32'd1);
            chk("at_hold_v", 32'(vtx_idx), 32'd1);
            chk("at_hold_b", 32'(busy), 32'd1);
            chk("at_rdy", 32'(u_if.req_ready), 32'b0010);
            chk("at_pav", 32'(u_if.pa_valid), 32'd0);
        end
        u_if.req_valid = 4'b0110;
        tick();
        chk("at_resume", 32'(vtx_idx), 32'd2);
        tick();
        chk("at_done", 32'(tri_count), 32'd1);
        tick();
        chk("at_next", 32'(grant_id), 32'd2);

        // backpressure
        do_reset();
        u_if.req_valid = 4'b0001;
        u_if.pa_ready = 1'b1;
        set_vtx(0, 32'd1);
        tick();
        bp = 5'b11001;
        nx = 0;
        for (int c = 0; c < 5; c++) begin
            u_if.pa_ready = bp[c];
            set_vtx(0, 32'(nx + 1));
            #1;
            chk("bp_x", u_if.pa_vertex_x, 32'(nx + 1));
            chk("bp_w", u_if.pa_vertex_w, 32'(nx + 1 + 32'h300));
            chk("bp_vtx", 32'(vtx_idx), 32'(nx));
            chk("bp_rdy", 32'(u_if.req_ready[0]), 32'(bp[c]));
            if (u_if.pa_valid && u_if.req_ready[0]) nx++;
            tick();
        end
        chk("bp_xfers", 32'(nx), 32'd3);
        chk("bp_tri", 32'(tri_count), 32'd1);
        chk("bp_idle", 32'(busy), 32'd0);
        u_if.pa_ready = 1'b1;
        set_vtx(0, 32'd16);

        // reset mid-triangle
        do_reset();
        u_if.req_valid = 4'b0001;
        repeat (4) tick();
        u_if.req_valid = 4'b0100;
        tick();
        chk("mr_grant", 32'(grant_id), 32'd2);
        tick();
        tick();
        chk("mr_vtx2", 32'(vtx_idx), 32'd2);
        rst = 1'b1;
        u_if.req_valid = 4'b0101;
        tick();
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_vtx", 32'(vtx_idx), 32'd0);
        chk("mr_tri", 32'(tri_count), 32'd0);
        chk("mr_pav", 32'(u_if.pa_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("mr_regrant", 32'(grant_id), 32'd0);
        chk("mr_rebusy", 32'(busy), 32'd1);

        // counter wrap on the CNT_W=2 copy
        do_reset();
        u_if.req_valid = 4'b0001;
        for (int t = 0; t < 5; t++) begin
            repeat (4) tick();
            chk("wrap_tri", 32'(tri_count2), 32'(exp_wrap[t]));
        end
        chk("wrap_wide", 32'(tri_count), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
